// File: rtl/inst_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module      : inst_pipe_regs
// Description : Instruction pipeline-register chain (IF/ID, ID/EX, EX/MEM,
//               MEM/WB) feeding the Control block. Advances one stage per
//               clock, inserts a one-cycle bubble on a load-use hazard and
//               squashes wrong-path instructions when a BEQ in EX/MEM is
//               taken.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NOP_WORD       bubble/squash word (SLL $0,$0,0 by default)
// Ports:
//   clock          in   1   rising-edge clock
//   reset          in   1   asynchronous active-high reset
//   IF_Inst        in   32  instruction word from fetch
//   IF_Valid       in   1   IF_Inst carries a real instruction
//   IF_Ready       out  1   fetch word consumed this cycle (PC advance)
//   Branch_Taken   in   1   BEQ comparison result for EX/MEM instruction
//   PR_IFID_Inst   out  32  IF/ID instruction register
//   PR_IDEX_Inst   out  32  ID/EX instruction register
//   PR_EXMEM_Inst  out  32  EX/MEM instruction register
//   PR_MEMWB_Inst  out  32  MEM/WB instruction register
//   Pipe_State     out  2   action of last edge: 0 RUN, 1 STALL, 2 FLUSH
//   Stall_Count    out  16  saturating load-use stall count
//   Flush_Count    out  16  saturating taken-branch flush count
// Configuration macro:
//   INST_PIPE_STATS_EN  when defined, Stall_Count/Flush_Count are real
//                       saturating counters; otherwise both read 16'h0000
//                       and no counter flops are built.
// ============================================================================
module inst_pipe_regs #(
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IF_Inst,
    input  logic        IF_Valid,
    output logic        IF_Ready,
    input  logic        Branch_Taken,
    output logic [31:0] PR_IFID_Inst,
    output logic [31:0] PR_IDEX_Inst,
    output logic [31:0] PR_EXMEM_Inst,
    output logic [31:0] PR_MEMWB_Inst,
    output logic [1:0]  Pipe_State,
    output logic [15:0] Stall_Count,
    output logic [15:0] Flush_Count
);

    localparam logic [5:0] c_OP_LW      = 6'b100011;
    localparam logic [5:0] c_OP_SW      = 6'b101011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;

    typedef enum logic [1:0] {
        PS_RUN   = 2'd0,
        PS_STALL = 2'd1,
        PS_FLUSH = 2'd2
    } pipe_state_t;

    logic [31:0] r_ifid;
    logic [31:0] r_idex;
    logic [31:0] r_exmem;
    logic [31:0] r_memwb;
    pipe_state_t r_state;

    logic [5:0]  w_idex_op;
    logic [4:0]  w_idex_rt;
    logic [5:0]  w_ifid_op;
    logic [4:0]  w_ifid_rs;
    logic [4:0]  w_ifid_rt;
    logic        w_ifid_reads_rt;
    logic        w_load_use;
    logic        w_flush;
    logic        w_stall;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    assign w_idex_op = r_idex[31:26];
    assign w_idex_rt = r_idex[20:16];
    assign w_ifid_op = r_ifid[31:26];
    assign w_ifid_rs = r_ifid[25:21];
    assign w_ifid_rt = r_ifid[20:16];

    // Only R-type, BEQ and SW actually read rt as a source; for I-type ALU
    // ops and loads the rt field is a destination and must not trigger.
    assign w_ifid_reads_rt = (w_ifid_op == c_OP_SPECIAL) ||
                             (w_ifid_op == c_OP_BEQ)     ||
                             (w_ifid_op == c_OP_SW);

    // A load into $0 never produces a usable value, so it cannot cause a stall.
    assign w_load_use = (w_idex_op == c_OP_LW) &&
                        (w_idex_rt != 5'd0)    &&
                        ((w_idex_rt == w_ifid_rs) ||
                         (w_ifid_reads_rt && (w_idex_rt == w_ifid_rt)));

    assign w_flush = Branch_Taken && (r_exmem[31:26] == c_OP_BEQ);

    // Flush squashes the dependent instruction, so a coinciding stall is moot.
    assign w_stall  = w_load_use && !w_flush;
    assign IF_Ready = !w_stall;

    // ------------------------------------------------------------------------
    // Pipeline registers and last-action state
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ifid  <= NOP_WORD;
            r_idex  <= NOP_WORD;
            r_exmem <= NOP_WORD;
            r_memwb <= NOP_WORD;
            r_state <= PS_RUN;
        end else if (w_flush) begin
            // The branch itself retires; everything younger is wrong-path.
            r_ifid  <= NOP_WORD;
            r_idex  <= NOP_WORD;
            r_exmem <= NOP_WORD;
            r_memwb <= r_exmem;
            r_state <= PS_FLUSH;
        end else if (w_load_use) begin
            // IF/ID holds the dependent instruction; a bubble goes to EX.
            r_idex  <= NOP_WORD;
            r_exmem <= r_idex;
            r_memwb <= r_exmem;
            r_state <= PS_STALL;
        end else begin
            r_ifid  <= IF_Valid ? IF_Inst : NOP_WORD;
            r_idex  <= r_ifid;
            r_exmem <= r_idex;
            r_memwb <= r_exmem;
            r_state <= PS_RUN;
        end
    end

    assign PR_IFID_Inst  = r_ifid;
    assign PR_IDEX_Inst  = r_idex;
    assign PR_EXMEM_Inst = r_exmem;
    assign PR_MEMWB_Inst = r_memwb;
    assign Pipe_State    = r_state;

    // ------------------------------------------------------------------------
    // Optional statistics counters (saturating, never wrap)
    // ------------------------------------------------------------------------
`ifdef INST_PIPE_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign Stall_Count = r_stall_cnt;
    assign Flush_Count = r_flush_cnt;
`else
    assign Stall_Count = 16'h0000;
    assign Flush_Count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_pipe_regs
// Description : Self-checking bench for inst_pipe_regs. A stage-array
//               reference model tracks the expected contents of the four
//               instruction registers, the last action and the counters.
//               Directed scenarios are followed by constrained-random traffic
//               built from a small register set so hazards occur often.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_pipe_regs;

    localparam logic [31:0] c_NOP = 32'h00000000;
    localparam logic [5:0]  c_LW  = 6'b100011;
    localparam logic [5:0]  c_SW  = 6'b101011;
    localparam logic [5:0]  c_BEQ = 6'b000100;
    localparam logic [5:0]  c_SPC = 6'b000000;
    localparam logic [5:0]  c_ADDI = 6'b001000;

    logic        clock;
    logic        reset;
    logic [31:0] IF_Inst;
    logic        IF_Valid;
    logic        IF_Ready;
    logic        Branch_Taken;
    logic [31:0] PR_IFID_Inst;
    logic [31:0] PR_IDEX_Inst;
    logic [31:0] PR_EXMEM_Inst;
    logic [31:0] PR_MEMWB_Inst;
    logic [1:0]  Pipe_State;
    logic [15:0] Stall_Count;
    logic [15:0] Flush_Count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stage[0]=IF/ID .. stage[3]=MEM/WB
    logic [31:0] m_stage [4];
    logic [1:0]  m_state;
    int          m_stalls;
    int          m_flushes;

    inst_pipe_regs #(.NOP_WORD(32'h00000000)) dut (
        .clock         (clock),
        .reset         (reset),
        .IF_Inst       (IF_Inst),
        .IF_Valid      (IF_Valid),
        .IF_Ready      (IF_Ready),
        .Branch_Taken  (Branch_Taken),
        .PR_IFID_Inst  (PR_IFID_Inst),
        .PR_IDEX_Inst  (PR_IDEX_Inst),
        .PR_EXMEM_Inst (PR_EXMEM_Inst),
        .PR_MEMWB_Inst (PR_MEMWB_Inst),
        .Pipe_State    (Pipe_State),
        .Stall_Count   (Stall_Count),
        .Flush_Count   (Flush_Count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Model helpers
    // ------------------------------------------------------------------------
    function automatic logic hazard(input logic [31:0] producer, input logic [31:0] consumer);
        logic [4:0] dst;
        dst = producer[20:16];
        if (producer[31:26] != c_LW || dst == 5'd0) return 1'b0;
        if (consumer[25:21] == dst) return 1'b1;
        if ((consumer[31:26] inside {c_SPC, c_BEQ, c_SW}) && consumer[20:16] == dst) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_count(input int n);
`ifdef INST_PIPE_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ifid"},  PR_IFID_Inst,  m_stage[0]);
        chk({tag, ".idex"},  PR_IDEX_Inst,  m_stage[1]);
        chk({tag, ".exmem"}, PR_EXMEM_Inst, m_stage[2]);
        chk({tag, ".memwb"}, PR_MEMWB_Inst, m_stage[3]);
        chk({tag, ".state"}, 32'(Pipe_State), 32'(m_state));
        chk({tag, ".stalls"}, 32'(Stall_Count), 32'(exp_count(m_stalls)));
        chk({tag, ".flushes"}, 32'(Flush_Count), 32'(exp_count(m_flushes)));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_stage[i] = c_NOP;
        m_state   = 2'd0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // One clock: drive inputs, check IF_Ready, clock, update model, check regs.
    task automatic step(input string tag, input logic [31:0] inst, input logic valid, input logic bt);
        logic flush, lu;
        IF_Inst      = inst;
        IF_Valid     = valid;
        Branch_Taken = bt;
        flush = bt && (m_stage[2][31:26] == c_BEQ);
        lu    = hazard(m_stage[1], m_stage[0]);
        #1;
        chk({tag, ".ready"}, 32'(IF_Ready), 32'(!(lu && !flush)));
        @(posedge clock);
        if (flush) begin
            m_stage[3] = m_stage[2];
            for (int i = 0; i < 3; i++) m_stage[i] = c_NOP;
            m_state = 2'd2;
            m_flushes++;
        end else if (lu) begin
            m_stage[3] = m_stage[2];
            m_stage[2] = m_stage[1];
            m_stage[1] = c_NOP;
            m_state = 2'd1;
            m_stalls++;
        end else begin
            for (int i = 3; i > 0; i--) m_stage[i] = m_stage[i-1];
            m_stage[0] = valid ? inst : c_NOP;
            m_state = 2'd0;
        end
        #1;
        check_regs(tag);
    endtask

    // Asynchronous assert between edges, release away from the edge.
    task automatic async_reset(input string tag);
        #2;
        Branch_Taken = 1'b0;
        IF_Valid     = 1'b0;
        reset        = 1'b1;
        #1;
        model_reset();
        check_regs({tag, ".async"});
        chk({tag, ".ready"}, 32'(IF_Ready), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_regs({tag, ".release"});
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        logic [4:0] rs, rt;
        case ($urandom_range(0, 4))
            0: op = c_LW;
            1: op = c_SW;
            2: op = c_BEQ;
            3: op = c_SPC;
            default: op = c_ADDI;
        endcase
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        return {op, rs, rt, 16'($urandom)};
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset        = 1'b1;
        IF_Inst      = 32'h0;
        IF_Valid     = 1'b0;
        Branch_Taken = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_regs("por");

        // Straight-line flow with fixed latency
        step("sl0", 32'h20020005, 1'b1, 1'b0);
        step("sl1", 32'h20030007, 1'b1, 1'b0);
        step("sl2", 32'h20040009, 1'b1, 1'b0);
        step("sl3", 32'h0, 1'b0, 1'b0);
        chk("sl.lat0", PR_MEMWB_Inst, 32'h20020005);
        step("sl4", 32'h0, 1'b0, 1'b0);
        chk("sl.lat1", PR_MEMWB_Inst, 32'h20030007);
        step("sl5", 32'h0, 1'b0, 1'b0);
        chk("sl.lat2", PR_MEMWB_Inst, 32'h20040009);

        // Reset mid-run with a full pipe
        for (int i = 0; i < 4; i++) step("fill", 32'h20020005, 1'b1, 1'b0);
        async_reset("rst_run");
        chk("rst_run.memwb0", PR_MEMWB_Inst, 32'h00000000);

        // Load-use: LW $8 then ADD using $8
        step("lu0", 32'h8C080000, 1'b1, 1'b0);
        step("lu1", 32'h01084820, 1'b1, 1'b0);
        step("lu2", 32'h20030007, 1'b1, 1'b0);
        chk("lu2.idex_bubble", PR_IDEX_Inst, 32'h00000000);
        chk("lu2.ifid_hold", PR_IFID_Inst, 32'h01084820);
        chk("lu2.state", 32'(Pipe_State), 32'd1);
        step("lu3", 32'h20030007, 1'b1, 1'b0);
        chk("lu3.add_adv", PR_IDEX_Inst, 32'h01084820);

        // No false stalls
        step("nf0", 32'h8C000000, 1'b1, 1'b0);
        step("nf1", 32'h01084820, 1'b1, 1'b0);
        step("nf2", 32'h8C080000, 1'b1, 1'b0);
        step("nf3", 32'h20090005, 1'b1, 1'b0);
        step("nf4", 32'h0, 1'b0, 1'b0);
        chk("nf4.state", 32'(Pipe_State), 32'd0);

        // Taken branch, then Branch_Taken on a non-BEQ
        step("br0", 32'h10000004, 1'b1, 1'b0);
        step("br1", 32'h20020005, 1'b1, 1'b0);
        step("br2", 32'h20030007, 1'b1, 1'b0);
        step("br3", 32'h20040009, 1'b1, 1'b1);
        chk("br3.memwb", PR_MEMWB_Inst, 32'h10000004);
        chk("br3.state", 32'(Pipe_State), 32'd2);
        step("br4", 32'h20050001, 1'b1, 1'b0);
        step("br5", 32'h0, 1'b0, 1'b0);
        step("br6", 32'h0, 1'b0, 1'b1);
        chk("br6.state", 32'(Pipe_State), 32'd0);

        // Flush and load-use in the same cycle
        step("co0", 32'h10000004, 1'b1, 1'b0);
        step("co1", 32'h8C080000, 1'b1, 1'b0);
        step("co2", 32'h01084820, 1'b1, 1'b0);
        step("co3", 32'h20020005, 1'b1, 1'b1);
        chk("co3.state", 32'(Pipe_State), 32'd2);

        // Reset while a stall is pending
        step("rs0", 32'h8C080000, 1'b1, 1'b0);
        step("rs1", 32'h01084820, 1'b1, 1'b0);
        IF_Inst = 32'h20020005;
        #1;
        chk("rs.ready_low", 32'(IF_Ready), 32'd0);
        async_reset("rst_stall");

        // Constrained-random traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd", rand_inst(), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
